// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame sequencer.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_WR    = 8'h01;
    localparam logic [7:0] CMD_RD    = 8'h02;

    localparam int unsigned FRAME_LEN = 5;

    // One state per frame byte awaited, plus ISSUE while the command is pending.
    typedef enum logic [$clog2(FRAME_LEN + 1)-1:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_ISSUE
    } state_e;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    function automatic logic [7:0] frame_sum(input cmd_t c);
        return 8'(c.op + c.addr + c.data);
    endfunction

    function automatic logic op_known(input logic [7:0] op);
        return (op == CMD_WR) || (op == CMD_RD);
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the receiver's held-high done flag into a single-cycle strobe with its byte.
module uart_byte_strobe (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx_rec,
    input  logic [7:0] rx_data,
    output logic       rx_stb_c,
    output logic [7:0] rx_byte_c
);

    logic rec_q;
    logic rec_d;

    always_comb rec_d = rx_rec;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rec_q <= 1'b0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rx_stb_c  = rx_rec & ~rec_q;
    // Byte is only meaningful while the flag is high; present zero otherwise.
    assign rx_byte_c = rx_rec ? rx_data : 8'h00;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/CMD/ADDR/DATA/CHK frames and issues one register command per valid frame.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 5000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx_rec,
    input  logic [7:0] rx_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_op,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       busy,
    output logic       err_chk,
    output logic       err_cmd,
    output logic       err_tmo,
    output logic       err_ovf
);

    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    logic       rx_stb;
    logic [7:0] rx_byte;

    uart_byte_strobe u_strobe (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_rec    (rx_rec),
        .rx_data   (rx_data),
        .rx_stb_c  (rx_stb),
        .rx_byte_c (rx_byte)
    );

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    cmd_t             cmd_q, cmd_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic             busy_q, busy_d;
    logic             err_chk_q, err_chk_d;
    logic             err_cmd_q, err_cmd_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_ovf_q, err_ovf_d;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_chk_q   <= 1'b0;
            err_cmd_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            err_chk_q   <= err_chk_d;
            err_cmd_q   <= err_cmd_d;
            err_tmo_q   <= err_tmo_d;
            err_ovf_q   <= err_ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        err_chk_d   = 1'b0;
        err_cmd_d   = 1'b0;
        err_tmo_d   = 1'b0;
        err_ovf_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (rx_stb && (rx_byte == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end
            end

            ST_CMD, ST_ADDR, ST_DATA, ST_CHK: begin
                // A strobe in the same cycle as the limit keeps the frame alive.
                if (rx_stb) begin
                    tmo_d = '0;
                    case (state_q)
                        ST_CMD: begin
                            cmd_d.op = rx_byte;
                            state_d  = ST_ADDR;
                        end
                        ST_ADDR: begin
                            cmd_d.addr = rx_byte;
                            state_d    = ST_DATA;
                        end
                        ST_DATA: begin
                            cmd_d.data = rx_byte;
                            state_d    = ST_CHK;
                        end
                        default: begin
                            if (rx_byte != frame_sum(cmd_q)) begin
                                err_chk_d = 1'b1;
                                state_d   = ST_IDLE;
                            end else if (!op_known(cmd_q.op)) begin
                                err_cmd_d = 1'b1;
                                state_d   = ST_IDLE;
                            end else begin
                                cmd_valid_d = 1'b1;
                                state_d     = ST_ISSUE;
                            end
                        end
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    err_tmo_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            ST_ISSUE: begin
                tmo_d = '0;
                // Bytes arriving while a command waits are dropped, SYNC included.
                if (rx_stb) begin
                    err_ovf_d = 1'b1;
                end
                if (cmd_valid_q && cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                tmo_d       = '0;
                cmd_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_q.op;
    assign cmd_addr  = cmd_q.addr;
    assign cmd_data  = cmd_q.data;
    assign busy      = busy_q;
    assign err_chk   = err_chk_q;
    assign err_cmd   = err_cmd_q;
    assign err_tmo   = err_tmo_q;
    assign err_ovf   = err_ovf_q;

endmodule
